yuv422_word_packer: RTL and testbench

//  Downstream stage of the RGB->YUV converter. Collects the 8-bit YUV 4:2:2 byte stream
//  (order U, Y0, V, Y1) into 32-bit words {U,Y0,V,Y1}.

---
 rtl/yuv422_word_packer_if.sv | 35 +++
 rtl/yuv422_word_packer.sv | 123 ++++++++++++
 tb/tb_yuv422_word_packer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/yuv422_word_packer_if.sv
// Byte-in / word-out port bundle for yuv422_word_packer.
//   slave  : the packer's view (receives bytes, produces words and status)
//   master : the producer/consumer view (drives bytes and word_ready)
// Signals:
//   in_valid, yuv_in, sync_clr : byte stream from the converter
//   in_ready                   : FIFO not full (registered)
//   word_valid, word_ready     : word handshake toward memory/bus logic
//   word_out                   : packed {U,Y0,V,Y1}
//   fill_level, overflow       : FIFO occupancy and sticky overrun flag
interface yuv422_word_packer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BW    = 8
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic              in_valid;
    logic [BW-1:0]     yuv_in;
    logic              sync_clr;
    logic              in_ready;
    logic              word_valid;
    logic              word_ready;
    logic [4*BW-1:0]   word_out;
    logic [CW-1:0]     fill_level;
    logic              overflow;

    modport slave (
        input  in_valid, yuv_in, sync_clr, word_ready,
        output in_ready, word_valid, word_out, fill_level, overflow
    );

    modport master (
        output in_valid, yuv_in, sync_clr, word_ready,
        input  in_ready, word_valid, word_out, fill_level, overflow
    );
endinterface

// File: rtl/yuv422_word_packer.sv
// Packs a YUV 4:2:2 byte stream (U, Y0, V, Y1) into 32-bit words {U,Y0,V,Y1}, buffers them
// in a show-ahead FIFO and presents them on a valid/ready word port. The upstream converter
// ignores backpressure, so bytes arriving while in_ready=0 are dropped and flagged in a
// sticky overflow bit.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : yuv422_word_packer_if.slave (byte input, word output, status)
module yuv422_word_packer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned BW    = 8
) (
    input logic                    clk,
    input logic                    reset,
    yuv422_word_packer_if.slave    bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = 4 * BW;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [1:0]    phase_q, phase_d;
    logic [1:0]    slot;
    logic [BW-1:0] u_q, u_d, y0_q, y0_d, v_q, v_d;
    logic [WW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] word_out_q, word_out_d;
    logic [WW-1:0] push_word;
    logic          word_valid_q;
    logic          in_ready_q;
    logic          overflow_q, overflow_d;
    logic          accept, push, pop;

    always_comb begin
        accept    = bus.in_valid && in_ready_q;
        pop       = word_valid_q && bus.word_ready;
        // sync_clr forces the accepted byte into slot U, so it can never complete a word
        push      = accept && !bus.sync_clr && (phase_q == 2'd3);
        push_word = {u_q, y0_q, v_q, bus.yuv_in};

        phase_d = phase_q;
        u_d     = u_q;
        y0_d    = y0_q;
        v_d     = v_q;
        slot    = bus.sync_clr ? 2'd0 : phase_q;

        if (bus.sync_clr) begin
            phase_d = 2'd0;
        end
        if (accept) begin
            unique case (slot)
                2'd0:    u_d  = bus.yuv_in;
                2'd1:    y0_d = bus.yuv_in;
                2'd2:    v_d  = bus.yuv_in;
                default: ;  // Y1 goes straight into push_word
            endcase
            phase_d = slot + 2'd1;
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q || (bus.in_valid && !in_ready_q);

        // Next head: the word being pushed bypasses the memory when it becomes the head
        // (FIFO empty, or its only word is popped this cycle); otherwise read the array.
        // With the FIFO going empty, word_out keeps its last value.
        word_out_d = word_out_q;
        if (push && ((count_q == '0) || ((count_q == CW'(1)) && pop))) begin
            word_out_d = push_word;
        end else if (count_d != '0) begin
            word_out_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q      <= 2'd0;
            u_q          <= '0;
            y0_q         <= '0;
            v_q          <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            u_q          <= u_d;
            y0_q         <= y0_d;
            v_q          <= v_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            word_out_q   <= word_out_d;
            word_valid_q <= (count_d != '0);
            in_ready_q   <= (count_d != Full);
            overflow_q   <= overflow_d;
        end
    end

    // Storage is not reset; pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word_out   = word_out_q;
    assign bus.fill_level = count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_yuv422_word_packer.sv
// Scoreboard bench for yuv422_word_packer: expected words are queued as the 4th byte of a
// group is driven and compared whenever the DUT hands a word over (valid && ready).
module tb_yuv422_word_packer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BW    = 8;

    logic clk;
    logic reset;

    yuv422_word_packer_if #(.DEPTH(DEPTH), .BW(BW)) bus ();

    yuv422_word_packer #(.DEPTH(DEPTH), .BW(BW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    logic [31:0] sb [$];
    int          m_phase;
    logic [7:0]  m_bytes [4];
    bit          rnd_on;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Word handover: compare head against scoreboard front.
    always @(negedge clk) begin
        if (reset && bus.word_valid && bus.word_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                check_eq("word", bus.word_out, sb.pop_front());
            end
        end
    end

    // Drive a byte now (caller is just after a posedge) and update the packing model.
    task automatic drive_now(input logic [7:0] b, input logic clr);
        bus.in_valid = 1'b1;
        bus.yuv_in   = b;
        bus.sync_clr = clr;
        if (clr) m_phase = 0;
        m_bytes[m_phase] = b;
        if (m_phase == 3) sb.push_back({m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]});
        m_phase = (m_phase + 1) % 4;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic clr);
        @(posedge clk); #1;
        drive_now(b, clr);
    endtask

    // Drive only when in_ready is high, as a well-behaved producer would.
    task automatic send_byte_fc(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && n < 100) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) check_eq("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        drive_now(b, 1'b0);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.sync_clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.word_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_phase  = 0;
        rnd_on   = 1'b0;
        reset    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.yuv_in     = '0;
        bus.sync_clr   = 1'b0;
        bus.word_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_eq("rst_valid", {31'd0, bus.word_valid}, 32'd0);
        check_eq("rst_word", bus.word_out, 32'd0);
        check_eq("rst_fill", 32'(bus.fill_level), 32'd0);
        check_eq("rst_ovf", {31'd0, bus.overflow}, 32'd0);
        check_eq("rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // 1: single word, valid for exactly one cycle one clock after the last byte
        bus.word_ready = 1'b1;
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h40, 1'b0);
        idle();
        @(negedge clk);
        check_eq("t1_valid_hi", {31'd0, bus.word_valid}, 32'd1);
        check_eq("t1_word", bus.word_out, 32'h10203040);
        @(negedge clk);
        check_eq("t1_valid_lo", {31'd0, bus.word_valid}, 32'd0);
        check_eq("t1_sb", 32'(sb.size()), 32'd0);

        // 2: fill to DEPTH, then overrun
        bus.word_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        idle();
        @(negedge clk);
        check_eq("t2_fill", 32'(bus.fill_level), 32'd4);
        check_eq("t2_ready", {31'd0, bus.in_ready}, 32'd0);
        check_eq("t2_ovf0", {31'd0, bus.overflow}, 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.yuv_in   = 8'h10;
        idle();
        @(negedge clk);
        check_eq("t2_ovf1", {31'd0, bus.overflow}, 32'd1);
        check_eq("t2_fill_after", 32'(bus.fill_level), 32'd4);
        bus.word_ready = 1'b1;
        drain();

        // 3: sync_clr discards a partial group
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        idle();
        drain();
        check_eq("t3_ovf_sticky", {31'd0, bus.overflow}, 32'd1);

        // 5: push and pop in the same cycle at fill_level 2
        bus.word_ready = 1'b0;
        for (int i = 0; i < 11; i++) send_byte(8'(8'h21 + i), 1'b0);
        send_byte(8'h2C, 1'b0);
        bus.word_ready = 1'b1;
        idle();
        bus.word_ready = 1'b0;
        @(negedge clk);
        check_eq("t5_fill", 32'(bus.fill_level), 32'd2);
        bus.word_ready = 1'b1;
        drain();

        // 4: reset mid-group with a non-empty FIFO
        bus.word_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_byte(8'(8'h50 + i), 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("t4_fill_pre", 32'(bus.fill_level), 32'd2);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        m_phase = 0;
        @(negedge clk);
        check_eq("t4_fill", 32'(bus.fill_level), 32'd0);
        check_eq("t4_valid", {31'd0, bus.word_valid}, 32'd0);
        check_eq("t4_ovf", {31'd0, bus.overflow}, 32'd0);
        check_eq("t4_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.word_ready = 1'b1;
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        send_byte(8'h64, 1'b0);
        idle();
        drain();

        // 6: random input gaps and random consumer readiness
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    bus.word_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 64; i++) begin
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) idle();
            send_byte_fc(8'($urandom_range(0, 255)));
        end
        idle();
        rnd_on = 1'b0;
        repeat (3) @(posedge clk);
        #2 bus.word_ready = 1'b1;
        drain();
        check_eq("t6_ovf", {31'd0, bus.overflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end
endmodule
